// File: rtl/branch_ctrl.sv
// Conditional-branch resolver with a 16-entry 2-bit predictor and a fixed two-cycle flush/redirect sequence.
// Optional BRANCH_CTRL_STATS_EN adds resolved-branch and mispredict counters.
module branch_ctrl (
`ifdef BRANCH_CTRL_STATS_EN
  output logic [31:0] o_br_count,
  output logic [31:0] o_mispred_count,
`endif
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_if_pc,
  output logic        o_pred_taken,
  input  logic        i_ex_valid,
  input  logic [2:0]  i_ex_funct3,
  input  logic [31:0] i_ex_pc,
  input  logic [31:0] i_ex_target,
  input  logic        i_ex_pred_taken,
  input  logic        i_br_less,
  input  logic        i_br_equal,
  output logic        o_br_un,
  input  logic        i_stall,
  output logic        o_flush,
  output logic        o_redirect_valid,
  output logic [31:0] o_redirect_pc
);

  typedef enum logic [1:0] {RUN = 2'd0, FLUSH1 = 2'd1, FLUSH2 = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [1:0]  ctr_q [16];
  logic [31:0] redirect_pc_q;
  logic        legal, taken, resolve, mispredict;
  logic [3:0]  ex_idx;
  logic        unused_if_pc_bits;

  assign unused_if_pc_bits = ^{i_if_pc[31:6], i_if_pc[1:0]};
  assign ex_idx       = i_ex_pc[5:2];
  assign o_br_un      = i_ex_funct3[1];
  assign o_pred_taken = ctr_q[i_if_pc[5:2]][1];

  always_comb begin
    legal = 1'b1;
    taken = 1'b0;
    case (i_ex_funct3)
      3'b000:          taken = i_br_equal;
      3'b001:          taken = !i_br_equal;
      3'b100, 3'b110:  taken = i_br_less;
      3'b101, 3'b111:  taken = !i_br_less;
      default:         legal = 1'b0;
    endcase
  end

  // Illegal encodings never resolve, so they neither train nor redirect.
  assign resolve    = i_ex_valid && !i_stall && (state_q == RUN) && legal;
  assign mispredict = resolve && (taken != i_ex_pred_taken);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= RUN;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (mispredict) state_d = FLUSH1;
      FLUSH1:  state_d = FLUSH2;
      FLUSH2:  state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    o_flush          = 1'b0;
    o_redirect_valid = 1'b0;
    case (state_q)
      FLUSH1: begin
        o_flush          = 1'b1;
        o_redirect_valid = 1'b1;
      end
      FLUSH2:  o_flush = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 16; i++) ctr_q[i] <= 2'b01;
    end else if (resolve) begin
      if (taken && ctr_q[ex_idx] != 2'b11)
        ctr_q[ex_idx] <= ctr_q[ex_idx] + 2'd1;
      else if (!taken && ctr_q[ex_idx] != 2'b00)
        ctr_q[ex_idx] <= ctr_q[ex_idx] - 2'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     redirect_pc_q <= 32'd0;
    else if (resolve) redirect_pc_q <= taken ? i_ex_target : i_ex_pc + 32'd4;
  end

  assign o_redirect_pc = redirect_pc_q;

`ifdef BRANCH_CTRL_STATS_EN
  logic [31:0] br_count_q, mispred_count_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      br_count_q      <= 32'd0;
      mispred_count_q <= 32'd0;
    end else begin
      if (resolve)    br_count_q      <= br_count_q + 32'd1;
      if (mispredict) mispred_count_q <= mispred_count_q + 32'd1;
    end
  end

  assign o_br_count      = br_count_q;
  assign o_mispred_count = mispred_count_q;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_branch_ctrl;

  logic        clk, rst_n;
  logic [31:0] if_pc, ex_pc, ex_target, redirect_pc;
  logic        pred_taken, ex_valid, ex_pred, less, equal, br_un, stall, flush, redirect_valid;
  logic [2:0]  f3;
`ifdef BRANCH_CTRL_STATS_EN
  logic [31:0] br_count, mispred_count;
`endif

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  int          m_ctr [16];
  int          m_fl;
  logic [31:0] m_rpc;
  logic [31:0] m_br, m_mis;

  branch_ctrl dut (
`ifdef BRANCH_CTRL_STATS_EN
    .o_br_count(br_count),
    .o_mispred_count(mispred_count),
`endif
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_if_pc(if_pc),
    .o_pred_taken(pred_taken),
    .i_ex_valid(ex_valid),
    .i_ex_funct3(f3),
    .i_ex_pc(ex_pc),
    .i_ex_target(ex_target),
    .i_ex_pred_taken(ex_pred),
    .i_br_less(less),
    .i_br_equal(equal),
    .o_br_un(br_un),
    .i_stall(stall),
    .o_flush(flush),
    .o_redirect_valid(redirect_valid),
    .o_redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // -1 = illegal encoding, otherwise 0/1 actual direction
  function automatic int ref_dir(input logic [2:0] fn, input logic lt, input logic eq);
    case (fn)
      3'd0:       return eq ? 1 : 0;
      3'd1:       return eq ? 0 : 1;
      3'd4, 3'd6: return lt ? 1 : 0;
      3'd5, 3'd7: return lt ? 0 : 1;
      default:    return -1;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_ctr[i] = 1;
    m_fl  = 0;
    m_rpc = 32'd0;
    m_br  = 32'd0;
    m_mis = 32'd0;
  endtask

  task automatic model_edge();
    int d;
    int k;
    if (m_fl > 0) begin
      m_fl = m_fl - 1;
    end else if (ex_valid && !stall) begin
      d = ref_dir(f3, less, equal);
      if (d >= 0) begin
        k = int'(ex_pc[5:2]);
        m_br = m_br + 1;
        if (d == 1) m_ctr[k] = (m_ctr[k] == 3) ? 3 : m_ctr[k] + 1;
        else        m_ctr[k] = (m_ctr[k] == 0) ? 0 : m_ctr[k] - 1;
        m_rpc = (d == 1) ? ex_target : ex_pc + 32'd4;
        if (d != int'(ex_pred)) begin
          m_fl  = 2;
          m_mis = m_mis + 1;
        end
      end
    end
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_br(input logic v, input logic [2:0] fn, input logic [31:0] pc,
                        input logic [31:0] tgt, input logic pr, input logic lt, input logic eq);
    ex_valid = v; f3 = fn; ex_pc = pc; ex_target = tgt; ex_pred = pr; less = lt; equal = eq;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    if_pc = 32'h40;
    stall = 1'b0;
    set_br(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    model_reset();
    #2;
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL reset_flush got=%b exp=0", flush); end
    checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL reset_rv got=%b exp=0", redirect_valid); end
    checks++; if (redirect_pc !== 32'h0) begin failures++; $display("FAIL reset_rpc got=%h exp=0", redirect_pc); end
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL reset_pred got=%b exp=0", pred_taken); end
`ifdef BRANCH_CTRL_STATS_EN
    checks++; if (br_count !== 32'h0) begin failures++; $display("FAIL reset_brcnt got=%0d exp=0", br_count); end
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL post_reset_flush got=%b exp=0", flush); end
  endtask

  task automatic test_beq_mispredict();
    set_br(1'b1, 3'b000, 32'h100, 32'h200, 1'b0, 1'b0, 1'b1);
    cyc();
    ex_valid = 1'b0;
    #1;
    checks++; if (flush !== 1'b1) begin failures++; $display("FAIL beq_flush1 got=%b exp=1", flush); end
    checks++; if (redirect_valid !== 1'b1) begin failures++; $display("FAIL beq_rv1 got=%b exp=1", redirect_valid); end
    checks++; if (redirect_pc !== 32'h200) begin failures++; $display("FAIL beq_rpc got=%h exp=00000200", redirect_pc); end
    cyc();
    checks++; if (flush !== 1'b1 || redirect_valid !== 1'b0) begin failures++; $display("FAIL beq_flush2 got=%b/%b exp=1/0", flush, redirect_valid); end
    cyc();
    checks++; if (flush !== 1'b0 || redirect_valid !== 1'b0) begin failures++; $display("FAIL beq_run got=%b/%b exp=0/0", flush, redirect_valid); end
    if_pc = 32'h100;
    #1;
    checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL beq_ctr_trained got=%b exp=1", pred_taken); end
  endtask

  task automatic test_bltu();
    set_br(1'b1, 3'b110, 32'h24, 32'h80, 1'b1, 1'b1, 1'b0);
    if_pc = 32'h24;
    #1;
    checks++; if (br_un !== 1'b1) begin failures++; $display("FAIL bltu_br_un got=%b exp=1", br_un); end
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL bltu_same_cycle got=%b exp=0", pred_taken); end
    cyc();
    ex_valid = 1'b0;
    #1;
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL bltu_noflush got=%b exp=0", flush); end
    checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL bltu_pred_after got=%b exp=1", pred_taken); end
  endtask

  task automatic test_saturate();
    if_pc = 32'h10;
    for (int i = 0; i < 3; i++) begin
      set_br(1'b1, 3'b001, 32'h10, 32'h400, 1'b1, 1'b0, 1'b0);
      cyc();
      checks++; if (flush !== 1'b0) begin failures++; $display("FAIL sat_noflush%0d got=%b exp=0", i, flush); end
    end
    set_br(1'b1, 3'b001, 32'h10, 32'h400, 1'b1, 1'b0, 1'b1);
    cyc();
    ex_valid = 1'b0;
    #1;
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h14) begin failures++; $display("FAIL sat_redirect got=%b/%h exp=1/00000014", redirect_valid, redirect_pc); end
    checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL sat_ctr10 got=%b exp=1", pred_taken); end
    cyc();
    cyc();
    // a second not-taken drops 10 -> 01; from a saturated 11 it would still predict taken
    set_br(1'b1, 3'b001, 32'h10, 32'h400, 1'b1, 1'b0, 1'b1);
    cyc();
    ex_valid = 1'b0;
    #1;
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL sat_ctr01 got=%b exp=0", pred_taken); end
    cyc();
    cyc();
  endtask

  task automatic test_flush_ignore();
    stall = 1'b0;
    set_br(1'b1, 3'b000, 32'h30, 32'h300, 1'b0, 1'b0, 1'b1);
    cyc();
    stall = 1'b1;
    set_br(1'b1, 3'b000, 32'h34, 32'h500, 1'b0, 1'b0, 1'b1);
    #1;
    checks++; if (flush !== 1'b1 || redirect_valid !== 1'b1 || redirect_pc !== 32'h300) begin failures++; $display("FAIL fi_flush1 got=%b/%b/%h exp=1/1/00000300", flush, redirect_valid, redirect_pc); end
    cyc();
    checks++; if (flush !== 1'b1 || redirect_valid !== 1'b0) begin failures++; $display("FAIL fi_flush2 got=%b/%b exp=1/0", flush, redirect_valid); end
    ex_valid = 1'b0;
    stall = 1'b0;
    cyc();
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL fi_len got=%b exp=0", flush); end
    cyc();
    checks++; if (flush !== 1'b0 || redirect_valid !== 1'b0) begin failures++; $display("FAIL fi_no_second got=%b/%b exp=0/0", flush, redirect_valid); end
    if_pc = 32'h34;
    #1;
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL fi_ctr_untouched got=%b exp=0", pred_taken); end
  endtask

  task automatic test_illegal();
`ifdef BRANCH_CTRL_STATS_EN
    logic [31:0] before;
    before = br_count;
`endif
    if_pc = 32'h38;
    set_br(1'b1, 3'b010, 32'h38, 32'h600, 1'b0, 1'b1, 1'b1);
    cyc();
    ex_valid = 1'b0;
    #1;
    checks++; if (flush !== 1'b0 || redirect_valid !== 1'b0) begin failures++; $display("FAIL ill_noredirect got=%b/%b exp=0/0", flush, redirect_valid); end
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL ill_noupdate got=%b exp=0", pred_taken); end
`ifdef BRANCH_CTRL_STATS_EN
    checks++; if (br_count !== before) begin failures++; $display("FAIL ill_brcnt got=%0d exp=%0d", br_count, before); end
`endif
  endtask

  task automatic test_reset_midflush();
    set_br(1'b1, 3'b100, 32'h3C, 32'h700, 1'b0, 1'b1, 1'b0);
    cyc();
    ex_valid = 1'b0;
    #1;
    checks++; if (flush !== 1'b1) begin failures++; $display("FAIL rmf_inflush got=%b exp=1", flush); end
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (flush !== 1'b0 || redirect_valid !== 1'b0 || redirect_pc !== 32'h0) begin failures++; $display("FAIL rmf_abort got=%b/%b/%h exp=0/0/0", flush, redirect_valid, redirect_pc); end
    if_pc = 32'h100;
    #1;
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL rmf_ctr_reset got=%b exp=0", pred_taken); end
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL rmf_run got=%b exp=0", flush); end
  endtask

  task automatic test_random();
    logic [31:0] pcs [4];
    int k;
    pcs[0] = 32'hFFFF_FFFC;
    pcs[1] = 32'h0000_1000;
    pcs[2] = 32'h8000_0040;
    pcs[3] = 32'h0000_0004;
    for (int n = 0; n < 600; n++) begin
      if_pc     = {$urandom_range(0, 63), 2'b00};
      ex_pc     = pcs[$urandom_range(0, 3)] + {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      k         = int'(ex_pc[5:2]);
      ex_target = $urandom & 32'hFFFF_FFFC;
      f3        = 3'($urandom_range(0, 7));
      less      = 1'($urandom_range(0, 1));
      equal     = 1'($urandom_range(0, 1));
      ex_valid  = ($urandom_range(0, 9) < 7);
      stall     = ($urandom_range(0, 9) < 2);
      ex_pred   = ($urandom_range(0, 3) == 0) ? 1'($urandom_range(0, 1)) : (m_ctr[k] >= 2);
      #1;
      checks++; if (pred_taken !== (m_ctr[if_pc[5:2]] >= 2)) begin failures++; $display("FAIL rnd_pred n=%0d got=%b exp=%b", n, pred_taken, (m_ctr[if_pc[5:2]] >= 2)); end
      checks++; if (br_un !== f3[1]) begin failures++; $display("FAIL rnd_br_un n=%0d got=%b exp=%b", n, br_un, f3[1]); end
      checks++; if (flush !== (m_fl > 0) || redirect_valid !== (m_fl == 2)) begin failures++; $display("FAIL rnd_flush n=%0d got=%b/%b exp=%b/%b", n, flush, redirect_valid, (m_fl > 0), (m_fl == 2)); end
      if (m_fl == 2) begin
        checks++; if (redirect_pc !== m_rpc) begin failures++; $display("FAIL rnd_rpc n=%0d got=%h exp=%h", n, redirect_pc, m_rpc); end
      end
`ifdef BRANCH_CTRL_STATS_EN
      checks++; if (br_count !== m_br || mispred_count !== m_mis) begin failures++; $display("FAIL rnd_stats n=%0d got=%0d/%0d exp=%0d/%0d", n, br_count, mispred_count, m_br, m_mis); end
`endif
      cyc();
    end
  endtask

  initial begin
    test_reset();
    test_beq_mispredict();
    test_bltu();
    test_saturate();
    test_flush_ignore();
    test_illegal();
    test_reset_midflush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 SHALL have port i_clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port i_rst_n, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have port i_if_pc, input, 32, fetch PC for prediction lookup.
REQ-004 SHALL have port o_pred_taken, output, 1, predicted direction for i_if_pc.
REQ-005 SHALL have port i_ex_valid, input, 1, EX stage holds a valid conditional branch.
REQ-006 SHALL have port i_ex_funct3, input, 3, branch funct3 of EX instruction.
REQ-007 SHALL have port i_ex_pc, input, 32, PC of EX branch.
REQ-008 SHALL have port i_ex_target, input, 32, computed branch target.
REQ-009 SHALL have port i_ex_pred_taken, input, 1, prediction carried down the pipe with the branch.
REQ-010 SHALL have port i_br_less, input, 1, comparator less-than result.
REQ-011 SHALL have port i_br_equal, input, 1, comparator equal result.
REQ-012 SHALL have port o_br_un, output, 1, unsigned-compare select driven to the comparator.
REQ-013 SHALL have port i_stall, input, 1, pipeline stall; EX contents held.
REQ-014 SHALL have port o_flush, output, 1, squash IF/ID/EX wrong-path instructions.
REQ-015 SHALL have port o_redirect_valid, output, 1, load o_redirect_pc into PC.
REQ-016 SHALL have port o_redirect_pc, output, 32, corrected fetch address.

Function
REQ-017 o_br_un SHALL be combinational = i_ex_funct3[1].
REQ-018 Actual direction SHALL be: 000 equal; 001 !equal; 100/110 less; 101/111 !less; 010/011 illegal -> not taken, no table update, no redirect.
REQ-019 Predictor SHALL be 16 two-bit saturating counters indexed by PC[5:2]; o_pred_taken = counter[i_if_pc[5:2]][1], combinational.
REQ-020 A branch SHALL resolve when i_ex_valid=1, i_stall=0, state=RUN; unresolved branches cause no side effects.
REQ-021 On resolve, counter[i_ex_pc[5:2]] SHALL increment if taken, decrement otherwise, saturating at 3 and 0, written at that clock edge.
REQ-022 Same-cycle lookup and update of one index SHALL return the pre-update value.
REQ-023 Mispredict = resolved branch with direction != i_ex_pred_taken.
REQ-024 FSM states SHALL be RUN, FLUSH1, FLUSH2; RUN->FLUSH1 on mispredict; FLUSH1->FLUSH2; FLUSH2->RUN unconditionally; i_stall ignored in FLUSH states.
REQ-025 o_flush SHALL be 1 exactly in FLUSH1 and FLUSH2 (registered, one cycle after resolve).
REQ-026 o_redirect_valid SHALL be 1 only in FLUSH1; o_redirect_pc SHALL be registered at resolve: taken ? i_ex_target : i_ex_pc+4 (32-bit wrap).
REQ-027 In FLUSH1/FLUSH2, branches in EX SHALL be ignored (wrong path): no update, no redirect.
REQ-028 Correct predictions SHALL leave state RUN and outputs o_flush/o_redirect_valid at 0.

Reset
REQ-029 i_rst_n=0 SHALL immediately force state RUN, all counters 01 (weakly not-taken), o_flush=0, o_redirect_valid=0, o_redirect_pc=0.
REQ-030 Reset mid-flush SHALL abort the flush; first edge after release is in RUN.

Configuration
REQ-031 With BRANCH_CTRL_STATS_EN defined, SHALL add outputs o_br_count[31:0] and o_mispred_count[31:0], reset 0, incrementing per resolved branch / mispredict, wrapping at 2^32; undefined, SHALL omit ports and counters, all other behaviour identical.

Verification
REQ-032 Reset then i_if_pc=0x40 -> o_pred_taken=0; counter index 0 reads 01.
REQ-033 BEQ pc=0x100, equal=1, pred=0, target=0x200 -> next cycle o_flush=1, o_redirect_valid=1, o_redirect_pc=0x200; following cycle o_flush=1, redirect_valid=0; then RUN.
REQ-034 BLTU less=1 pred=1 -> o_br_un=1, no flush; counter pc[5:2] 01->10, lookup same pc then o_pred_taken=1.
REQ-035 Three taken BNE at pc=0x10 -> counter saturates 11; one not-taken, pred=1 -> counter 10, redirect_pc=0x14.
REQ-036 Mispredict followed by a branch in EX during FLUSH1 with i_stall=1 -> second branch ignored, no counter change, flush length exactly 2.
REQ-037 funct3=010 with i_ex_valid=1 -> no redirect, no update; with BRANCH_CTRL_STATS_EN, o_br_count unchanged.
